// File: rtl/vrc_bank_if.sv
// Bus-side write channels into the VRC2 bank-register controller:
// decoded CPU register writes and loader preset writes.
interface vrc_bank_if;
  logic        cpu_wr_req;
  logic [14:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        init_valid;
  logic [4:0]  init_index;
  logic [7:0]  init_data;
  logic        init_ready;

  modport master (
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    output init_valid, init_index, init_data,
    input  init_ready
  );

  modport slave (
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    input  init_valid, init_index, init_data,
    output init_ready
  );
endinterface

// File: rtl/vrc_bank_ctrl.sv
// VRC2 bank-register controller: ordered CPU write queue with
// strict priority over loader presets, PRG/mirroring/CHR registers.
module vrc_bank_ctrl #(
  parameter bit ATOMIC_CHR = 1'b0
) (
  input  logic       m2,
  input  logic       rst_n,
  vrc_bank_if.slave  bus,
  input  logic [2:0] chr_sel,
  output logic [4:0] prg_bank0,
  output logic [4:0] prg_bank1,
  output logic [1:0] mirroring,
  output logic [7:0] chr_bank,
  output logic       busy,
  output logic       wr_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t     state;
  logic [9:0] fifo [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [7:0] chr [8];
  logic [2:0] sh_bank;
  logic [3:0] sh_nib;
  logic       sh_valid;

  // Held low in operation; lets a bench stall the drain side.
  logic pop_stall;
  assign pop_stall = 1'b0;

  logic       pop;
  logic       push;
  logic       drop;
  logic       init_fire;
  logic [2:0] h_reg;
  logic       h_hi;
  logic       h_a0;
  logic [4:0] h_data;
  logic [1:0] h_off;
  logic [2:0] h_bank;
  logic       unused;

  assign pop  = (state != IDLE) && !pop_stall;
  assign push = bus.cpu_wr_req && (state != FULL || pop);
  assign drop = bus.cpu_wr_req && (state == FULL) && !pop;

  assign bus.init_ready = (state == IDLE) && !bus.cpu_wr_req;
  assign init_fire = bus.init_valid && bus.init_ready;

  assign {h_reg, h_hi, h_a0, h_data} = fifo[rd_ptr];
  assign h_off  = h_reg[1:0] - 2'd3;
  assign h_bank = {h_off, h_a0};

  assign busy     = (state != IDLE);
  assign chr_bank = chr[chr_sel];

  assign unused = ^{bus.cpu_wr_addr[11:2], bus.cpu_wr_data[7:5]};

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
      wr_overflow <= 1'b0;
      prg_bank0   <= '0;
      prg_bank1   <= '0;
      mirroring   <= '0;
      sh_bank     <= '0;
      sh_nib      <= '0;
      sh_valid    <= 1'b0;
      for (int i = 0; i < 8; i++) chr[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {bus.cpu_wr_addr[14:12],
                         bus.cpu_wr_addr[1:0],
                         bus.cpu_wr_data[4:0]};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (drop) wr_overflow <= 1'b1;

      case ({push, pop})
        2'b10: state <= (state == IDLE) ? PEND : FULL;
        2'b01: state <= (state == FULL) ? PEND : IDLE;
        default: ;
      endcase

      if (pop) begin
        unique case (1'b1)
          (h_reg == 3'b000): prg_bank0 <= h_data;
          (h_reg == 3'b010): prg_bank1 <= h_data;
          (h_reg == 3'b001): mirroring <= h_data[1:0];
          (h_reg >= 3'd3 && h_reg <= 3'd6): begin
            if (!ATOMIC_CHR) begin
              if (h_hi) chr[h_bank][7:4] <= h_data[3:0];
              else      chr[h_bank][3:0] <= h_data[3:0];
            end else if (!h_hi) begin
              sh_bank  <= h_bank;
              sh_nib   <= h_data[3:0];
              sh_valid <= 1'b1;
            end else if (sh_valid && sh_bank == h_bank) begin
              chr[h_bank] <= {h_data[3:0], sh_nib};
              sh_valid    <= 1'b0;
            end else begin
              chr[h_bank][7:4] <= h_data[3:0];
            end
          end
          default: ;
        endcase
      end else if (init_fire) begin
        unique case (1'b1)
          (bus.init_index == 5'd0):
            prg_bank0 <= bus.init_data[4:0];
          (bus.init_index == 5'd1):
            prg_bank1 <= bus.init_data[4:0];
          (bus.init_index == 5'd2):
            mirroring <= bus.init_data[1:0];
          (bus.init_index[4:3] == 2'b01): begin
            chr[bus.init_index[2:0]] <= bus.init_data;
            if (sh_valid && sh_bank == bus.init_index[2:0])
              sh_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vrc_bank_ctrl.sv
// Scoreboard bench for vrc_bank_ctrl, running the plain and the
// atomic-CHR variants side by side on identical stimulus.
module tb_vrc_bank_ctrl;

  logic m2 = 1'b0;
  logic rst_n = 1'b0;
  always #5 m2 = ~m2;

  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        init_valid;
  logic [4:0]  init_index;
  logic [7:0]  init_data;
  logic [2:0]  chr_sel;

  vrc_bank_if bus0 ();
  vrc_bank_if bus1 ();

  assign bus0.cpu_wr_req  = cpu_req;
  assign bus0.cpu_wr_addr = cpu_addr;
  assign bus0.cpu_wr_data = cpu_data;
  assign bus0.init_valid  = init_valid;
  assign bus0.init_index  = init_index;
  assign bus0.init_data   = init_data;
  assign bus1.cpu_wr_req  = cpu_req;
  assign bus1.cpu_wr_addr = cpu_addr;
  assign bus1.cpu_wr_data = cpu_data;
  assign bus1.init_valid  = init_valid;
  assign bus1.init_index  = init_index;
  assign bus1.init_data   = init_data;

  logic [4:0] a_p0, a_p1, b_p0, b_p1;
  logic [1:0] a_mir, b_mir;
  logic [7:0] a_chr, b_chr;
  logic       a_busy, b_busy, a_ovf, b_ovf;

  vrc_bank_ctrl #(.ATOMIC_CHR(1'b0)) u_dut0 (
    .m2(m2), .rst_n(rst_n), .bus(bus0.slave), .chr_sel(chr_sel),
    .prg_bank0(a_p0), .prg_bank1(a_p1), .mirroring(a_mir),
    .chr_bank(a_chr), .busy(a_busy), .wr_overflow(a_ovf)
  );

  vrc_bank_ctrl #(.ATOMIC_CHR(1'b1)) u_dut1 (
    .m2(m2), .rst_n(rst_n), .bus(bus1.slave), .chr_sel(chr_sel),
    .prg_bank0(b_p0), .prg_bank1(b_p1), .mirroring(b_mir),
    .chr_bank(b_chr), .busy(b_busy), .wr_overflow(b_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge m2) cyc <= cyc + 1;

  // Reference model of the register file (c0: plain, c1: atomic).
  logic [4:0] m_p0, m_p1;
  logic [1:0] m_mir;
  logic [7:0] m_chr0 [8];
  logic [7:0] m_chr1 [8];
  logic [2:0] m_sb;
  logic [3:0] m_sn;
  logic       m_sv;

  typedef struct {
    int         due;
    logic [4:0] p0;
    logic [4:0] p1;
    logic [1:0] mir;
    logic [2:0] sel;
    logic [7:0] c0;
    logic [7:0] c1;
  } exp_t;

  exp_t sb[$];

  function automatic void model_reset();
    m_p0 = '0; m_p1 = '0; m_mir = '0;
    m_sb = '0; m_sn = '0; m_sv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_chr0[i] = '0;
      m_chr1[i] = '0;
    end
  endfunction

  function automatic logic [2:0] model_cpu(input logic [14:0] a,
                                           input logic [7:0] d);
    int r;
    int b;
    r = int'(a[14:12]);
    b = 0;
    case (r)
      0: m_p0 = d[4:0];
      2: m_p1 = d[4:0];
      1: m_mir = d[1:0];
      3, 4, 5, 6: begin
        b = 2 * (r - 3) + int'(a[0]);
        if (a[1]) m_chr0[b][7:4] = d[3:0];
        else      m_chr0[b][3:0] = d[3:0];
        if (!a[1]) begin
          m_sb = 3'(b); m_sn = d[3:0]; m_sv = 1'b1;
        end else if (m_sv && m_sb == 3'(b)) begin
          m_chr1[b] = {d[3:0], m_sn};
          m_sv = 1'b0;
        end else begin
          m_chr1[b][7:4] = d[3:0];
        end
      end
      default: ;
    endcase
    return 3'(b);
  endfunction

  function automatic logic [2:0] model_init(input logic [4:0] idx,
                                            input logic [7:0] d);
    if (idx == 5'd0) m_p0 = d[4:0];
    else if (idx == 5'd1) m_p1 = d[4:0];
    else if (idx == 5'd2) m_mir = d[1:0];
    else if (idx >= 5'd8 && idx <= 5'd15) begin
      m_chr0[idx - 5'd8] = d;
      m_chr1[idx - 5'd8] = d;
      if (m_sv && m_sb == idx[2:0]) m_sv = 1'b0;
      return idx[2:0];
    end
    return 3'd0;
  endfunction

  function automatic exp_t snap(input int due, input logic [2:0] sel);
    exp_t e;
    e.due = due; e.p0 = m_p0; e.p1 = m_p1; e.mir = m_mir;
    e.sel = sel; e.c0 = m_chr0[sel]; e.c1 = m_chr1[sel];
    return e;
  endfunction

  // Scoreboard: pop each expectation once its update is due.
  always @(negedge m2) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chr_sel = e.sel;
      #1;
      n_tests++;
      if (a_p0 !== e.p0 || b_p0 !== e.p0 || a_p1 !== e.p1 ||
          b_p1 !== e.p1 || a_mir !== e.mir || b_mir !== e.mir ||
          a_chr !== e.c0 || b_chr !== e.c1) begin
        n_fail++;
        $display("FAIL sb_state cyc=%0d got p0=%h/%h p1=%h/%h mir=%h/%h chr[%0d]=%h/%h want p0=%h p1=%h mir=%h chr=%h/%h",
                 cyc, a_p0, b_p0, a_p1, b_p1, a_mir, b_mir, e.sel,
                 a_chr, b_chr, e.p0, e.p1, e.mir, e.c0, e.c1);
      end
    end
  end

  task automatic tick();
    @(posedge m2);
    #2;
  endtask

  task automatic cpu_issue(input logic [14:0] a, input logic [7:0] d);
    logic [2:0] s;
    cpu_req = 1'b1; cpu_addr = a; cpu_data = d;
    s = model_cpu(a, d);
    sb.push_back(snap(cyc + 2, s));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_p0, a_p1, a_mir, a_chr, a_busy, a_ovf} !== '0 ||
        {b_p0, b_p1, b_mir, b_chr, b_busy, b_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got a=%h b=%h want 0",
               {a_p0, a_p1, a_mir, a_chr, a_busy, a_ovf},
               {b_p0, b_p1, b_mir, b_chr, b_busy, b_ovf});
    end
    @(negedge m2);
    rst_n = 1'b1;
    model_reset();
    tick();
    n_tests++;
    if ({a_p0, a_p1, a_mir, a_chr, a_busy, a_ovf} !== '0 ||
        {b_p0, b_p1, b_mir, b_chr, b_busy, b_ovf} !== '0 ||
        bus0.init_ready !== 1'b1 || bus1.init_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release got a=%h b=%h rdy=%b%b want 0 rdy=11",
               {a_p0, a_p1, a_mir, a_chr, a_busy, a_ovf},
               {b_p0, b_p1, b_mir, b_chr, b_busy, b_ovf},
               bus0.init_ready, bus1.init_ready);
    end
  endtask

  task automatic test_prg();
    logic [14:0] ad [3] = '{15'h0000, 15'h2000, 15'h1000};
    logic [7:0]  dt [3] = '{8'h1F, 8'h03, 8'h02};
    logic [4:0] pre;
    for (int i = 0; i < 3; i++) begin
      pre = m_p0;
      cpu_issue(ad[i], dt[i]);
      tick();
      n_tests++;
      if (a_busy !== 1'b1 || b_busy !== 1'b1 ||
          a_ovf !== 1'b0 || b_ovf !== 1'b0 ||
          a_p0 !== pre || b_p0 !== pre) begin
        n_fail++;
        $display("FAIL prg_in_flight[%0d] got busy=%b%b ovf=%b%b p0=%h/%h want busy=11 ovf=00 p0=%h",
                 i, a_busy, b_busy, a_ovf, b_ovf, a_p0, b_p0, pre);
      end
    end
    cpu_req = 1'b0;
    tick();
    n_tests++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prg_drain got busy=%b%b want 00", a_busy, b_busy);
    end
    tick();
  endtask

  task automatic test_chr();
    logic [14:0] ad [3] = '{15'h3000, 15'h3002, 15'h3001};
    logic [7:0]  dt [3] = '{8'h05, 8'h0A, 8'h07};
    for (int i = 0; i < 3; i++) begin
      cpu_issue(ad[i], dt[i]);
      tick();
    end
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_atomic();
    logic [14:0] ad [7] = '{15'h4000, 15'h4002, 15'h4001, 15'h5002,
                            15'h4003, 15'h4000, 15'h4001};
    logic [7:0]  dt [7] = '{8'h04, 8'h0B, 8'h09, 8'h06,
                            8'h01, 8'h01, 8'h02};
    for (int i = 0; i < 7; i++) begin
      cpu_issue(ad[i], dt[i]);
      tick();
    end
    cpu_issue(15'h4002, 8'h03);
    tick();
    cpu_issue(15'h4003, 8'h05);
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_init_shadow();
    logic [4:0] ix [4] = '{5'd11, 5'd2, 5'd20, 5'd0};
    logic [7:0] dv [4] = '{8'h22, 8'h01, 8'hFF, 8'hE7};
    logic [2:0] s;
    cpu_issue(15'h4001, 8'h05);
    tick();
    cpu_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      init_valid = 1'b1; init_index = ix[i]; init_data = dv[i];
      #1;
      n_tests++;
      if (bus0.init_ready !== 1'b1 || bus1.init_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL init_ready_idle[%0d] got %b%b want 11",
                 i, bus0.init_ready, bus1.init_ready);
      end
      s = model_init(ix[i], dv[i]);
      sb.push_back(snap(cyc + 1, s));
      tick();
      init_valid = 1'b0;
    end
    cpu_issue(15'h4003, 8'h09);
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_init_block();
    int waits;
    bit done;
    logic [2:0] s;
    init_valid = 1'b1; init_index = 5'd9; init_data = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      cpu_issue(15'h0000, 8'(k + 4));
      #1;
      n_tests++;
      if (bus0.init_ready !== 1'b0 || bus1.init_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL init_blocked[%0d] got %b%b want 00",
                 k, bus0.init_ready, bus1.init_ready);
      end
      tick();
    end
    cpu_req = 1'b0;
    waits = 0;
    done = 1'b0;
    for (int w = 0; w < 6 && !done; w++) begin
      #1;
      if (bus0.init_ready === 1'b1 && bus1.init_ready === 1'b1) begin
        s = model_init(5'd9, 8'h3C);
        sb.push_back(snap(cyc + 1, s));
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    init_valid = 1'b0;
    n_tests++;
    if (!done || waits != 1) begin
      n_fail++;
      $display("FAIL init_first_idle got done=%0b waits=%0d want done=1 waits=1",
               done, waits);
    end
    tick();
    tick();
  endtask

  task automatic test_overflow();
    logic [2:0] s;
    force u_dut0.pop_stall = 1'b1;
    force u_dut1.pop_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cpu_req = 1'b1; cpu_addr = 15'h0000; cpu_data = 8'(i);
      if (i < 3) s = model_cpu(15'h0000, 8'(i));
      tick();
      n_tests++;
      if (a_ovf !== (i == 3) || b_ovf !== (i == 3) ||
          a_busy !== 1'b1 || b_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_push[%0d] got ovf=%b%b busy=%b%b want ovf=%0d busy=11",
                 i, a_ovf, b_ovf, a_busy, b_busy, (i == 3));
      end
    end
    cpu_req = 1'b0;
    #1;
    n_tests++;
    if (bus0.init_ready !== 1'b0 || bus1.init_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_init_ready got %b%b want 00",
               bus0.init_ready, bus1.init_ready);
    end
    release u_dut0.pop_stall;
    release u_dut1.pop_stall;
    tick(); tick(); tick();
    n_tests++;
    if (a_p0 !== m_p0 || b_p0 !== m_p0 || a_ovf !== 1'b1 ||
        b_ovf !== 1'b1 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain got p0=%h/%h ovf=%b%b busy=%b%b want p0=%h ovf=11 busy=00",
               a_p0, b_p0, a_ovf, b_ovf, a_busy, b_busy, m_p0);
    end
  endtask

  task automatic test_reset_busy();
    cpu_issue(15'h2000, 8'h15);
    tick();
    n_tests++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre got busy=%b%b want 11", a_busy, b_busy);
    end
    sb.delete();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({a_p0, a_p1, a_mir, a_busy, a_ovf} !== '0 ||
        {b_p0, b_p1, b_mir, b_busy, b_ovf} !== '0) begin
      n_fail++;
      $display("FAIL rst_async got a=%h b=%h want 0",
               {a_p0, a_p1, a_mir, a_busy, a_ovf},
               {b_p0, b_p1, b_mir, b_busy, b_ovf});
    end
    @(negedge m2);
    rst_n = 1'b1;
    tick(); tick();
    n_tests++;
    if (a_p1 !== 5'd0 || b_p1 !== 5'd0 || a_busy !== 1'b0 ||
        b_busy !== 1'b0 || a_chr !== 8'd0 || b_chr !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_lost_write got p1=%h/%h busy=%b%b chr=%h/%h want 0",
               a_p1, b_p1, a_busy, b_busy, a_chr, b_chr);
    end
  endtask

  initial begin
    cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    init_valid = 1'b0; init_index = '0; init_data = '0;
    chr_sel = '0;
    model_reset();
    test_reset();
    test_prg();
    test_chr();
    test_atomic();
    test_init_shadow();
    test_init_block();
    test_overflow();
    test_reset_busy();
    tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
